// File: rtl/mcycle_sched_if.sv
// mcycle_sched_if: pipeline/multi-cycle-unit signal bundle for mcycle_sched.
//   master modport : the scheduler (consumes E/D-stage info and mc_busy,
//                    drives start/op, stall/hold, retire select, status).
//   slave modport  : the pipeline and the multi-cycle unit side.
//   PERF_W         : width of the optional performance counters.
interface mcycle_sched_if #(
  parameter int unsigned PERF_W = 32
);
  // pipeline / unit -> scheduler
  logic              ex_mc_valid;
  logic              ex_mc_op;
  logic [3:0]        ex_rd;
  logic              ex_regwrite;
  logic [3:0]        d_ra1;
  logic [3:0]        d_ra2;
  logic              d_mc_valid;
  logic              mc_busy;
  // scheduler -> pipeline / unit
  logic              mc_start;
  logic              mc_op;
  logic              stall_fd;
  logic              e_hold;
  logic              ret_sel;
  logic [3:0]        ret_rd;
  logic              pending;
  logic              err_overlap;
  logic [PERF_W-1:0] perf_busy_cnt;
  logic [PERF_W-1:0] perf_stall_cnt;

  modport master (
    input  ex_mc_valid, ex_mc_op, ex_rd, ex_regwrite,
           d_ra1, d_ra2, d_mc_valid, mc_busy,
    output mc_start, mc_op, stall_fd, e_hold, ret_sel, ret_rd,
           pending, err_overlap, perf_busy_cnt, perf_stall_cnt
  );

  modport slave (
    output ex_mc_valid, ex_mc_op, ex_rd, ex_regwrite,
           d_ra1, d_ra2, d_mc_valid, mc_busy,
    input  mc_start, mc_op, stall_fd, e_hold, ret_sel, ret_rd,
           pending, err_overlap, perf_busy_cnt, perf_stall_cnt
  );
endinterface

// File: rtl/mcycle_sched.sv
// mcycle_sched: sequencing controller for the shared multi-cycle
// multiply/divide unit of the 5-stage pipeline. Launches an op when it
// reaches E, tracks its destination (one-entry scoreboard), stalls
// dependent/conflicting D-stage instructions and retires the result into
// the E2M slot, forcing the slot after MAX_DEFER cycles of deferral.
//
// Ports:
//   CLK    : clock, rising edge
//   Reset  : synchronous, active-low reset
//   bus    : mcycle_sched_if.master (E/D-stage info, unit handshake,
//            stall/hold/retire controls, status, perf counters)
//
// Optional feature: define MCYCLE_SCHED_PERF_EN to enable the
// perf_busy_cnt / perf_stall_cnt counters; otherwise both read 0.
module mcycle_sched #(
  parameter int unsigned MAX_DEFER = 4,
  parameter int unsigned DEFER_W   = 3,
  parameter int unsigned PERF_W    = 32
) (
  input  logic           CLK,
  input  logic           Reset,
  mcycle_sched_if.master bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  localparam logic [DEFER_W-1:0] MAX_DEFER_C = DEFER_W'(MAX_DEFER);

  state_e             state_q, state_d;
  logic [3:0]         pend_rd_q, pend_rd_d;
  logic               pend_op_q, pend_op_d;
  logic               seen_busy_q, seen_busy_d;
  logic [DEFER_W-1:0] defer_cnt_q, defer_cnt_d;
  logic               err_q, err_d;

  logic               mc_start;
  logic               mc_op;
  logic               ret_sel;
  logic               e_hold;
  logic               stall_fd;
  logic               idle;
  logic               haz_en;
  logic [3:0]         haz_rd;

  always_ff @(posedge CLK) begin
    if (!Reset) begin
      state_q     <= IDLE;
      pend_rd_q   <= '0;
      pend_op_q   <= 1'b0;
      seen_busy_q <= 1'b0;
      defer_cnt_q <= '0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      pend_rd_q   <= pend_rd_d;
      pend_op_q   <= pend_op_d;
      seen_busy_q <= seen_busy_d;
      defer_cnt_q <= defer_cnt_d;
      err_q       <= err_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    pend_rd_d   = pend_rd_q;
    pend_op_d   = pend_op_q;
    seen_busy_d = seen_busy_q;
    defer_cnt_d = defer_cnt_q;
    mc_start    = 1'b0;
    mc_op       = 1'b0;
    ret_sel     = 1'b0;
    e_hold      = 1'b0;

    idle = (state_q == IDLE);

    // In IDLE the hazard source is the op launching this cycle; otherwise
    // it is the outstanding destination, and any D-stage multi-cycle op
    // conflicts for the single unit.
    haz_en   = idle ? bus.ex_mc_valid : 1'b1;
    haz_rd   = idle ? bus.ex_rd : pend_rd_q;
    stall_fd = haz_en && ((bus.d_ra1 == haz_rd) || (bus.d_ra2 == haz_rd) ||
                          bus.d_mc_valid);

    // A second op arriving while one is outstanding is dropped and flagged.
    err_d = err_q | (bus.ex_mc_valid && !idle);

    unique case (state_q)
      IDLE: begin
        if (bus.ex_mc_valid) begin
          mc_start    = 1'b1;
          mc_op       = bus.ex_mc_op;
          pend_rd_d   = bus.ex_rd;
          pend_op_d   = bus.ex_mc_op;
          seen_busy_d = 1'b0;
          state_d     = RUN;
        end
      end
      RUN: begin
        mc_op       = pend_op_q;
        seen_busy_d = seen_busy_q | bus.mc_busy;
        // Completion is the falling edge of busy, so a unit that raises
        // busy a few cycles late is not mistaken for finished.
        if (!bus.mc_busy && seen_busy_q) begin
          state_d     = DONE;
          defer_cnt_d = '0;
        end
      end
      DONE: begin
        mc_op = pend_op_q;
        if (!bus.ex_regwrite || (defer_cnt_q == MAX_DEFER_C)) begin
          ret_sel = 1'b1;
          e_hold  = bus.ex_regwrite;
          state_d = IDLE;
        end else if (defer_cnt_q != MAX_DEFER_C) begin
          defer_cnt_d = defer_cnt_q + DEFER_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign bus.mc_start    = mc_start;
  assign bus.mc_op       = mc_op;
  assign bus.stall_fd    = stall_fd;
  assign bus.e_hold      = e_hold;
  assign bus.ret_sel     = ret_sel;
  assign bus.ret_rd      = ret_sel ? pend_rd_q : '0;
  assign bus.pending     = !idle;
  assign bus.err_overlap = err_q;

`ifdef MCYCLE_SCHED_PERF_EN
  logic [PERF_W-1:0] perf_busy_q;
  logic [PERF_W-1:0] perf_stall_q;

  always_ff @(posedge CLK) begin
    if (!Reset) begin
      perf_busy_q  <= '0;
      perf_stall_q <= '0;
    end else begin
      if (!idle)    perf_busy_q  <= perf_busy_q + PERF_W'(1);
      if (stall_fd) perf_stall_q <= perf_stall_q + PERF_W'(1);
    end
  end

  assign bus.perf_busy_cnt  = perf_busy_q;
  assign bus.perf_stall_cnt = perf_stall_q;
`else
  assign bus.perf_busy_cnt  = {PERF_W{1'b0}};
  assign bus.perf_stall_cnt = {PERF_W{1'b0}};
`endif

endmodule

// File: tb/tb_mcycle_sched.sv
// tb_mcycle_sched: self-checking bench for mcycle_sched. IDLE-state vector
// table, hand-written multi-cycle sequences, then randomized traffic
// checked against a transaction-level timing model (launch time, busy
// window, deferral window).
module tb_mcycle_sched;
  localparam int unsigned MAX_DEFER = 4;
  localparam int unsigned DEFER_W   = 3;
  localparam int unsigned PERF_W    = 32;

  logic CLK = 1'b0;
  logic Reset;
  always #5 CLK = ~CLK;

  mcycle_sched_if #(.PERF_W(PERF_W)) bus ();

  mcycle_sched #(
    .MAX_DEFER(MAX_DEFER),
    .DEFER_W  (DEFER_W),
    .PERF_W   (PERF_W)
  ) dut (
    .CLK  (CLK),
    .Reset(Reset),
    .bus  (bus)
  );

  typedef struct {
    logic       v;
    logic       op;
    logic [3:0] rd;
    logic       rw;
    logic [3:0] ra1;
    logic [3:0] ra2;
    logic       dmc;
    logic       rst;   // 0 = reset asserted this cycle
    int         d;     // busy start delay after launch (if launched)
    int         L;     // busy length (if launched)
  } stim_t;

  typedef struct {
    logic       v;
    logic       op;
    logic [3:0] rd;
    logic [3:0] ra1;
    logic [3:0] ra2;
    logic       dmc;
    logic       e_start;
    logic       e_stall;
  } vec_t;

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;

  // transaction-level model
  bit          m_act;
  int          m_t0, m_d, m_L;
  logic [3:0]  m_rd;
  logic        m_op;
  bit          m_err;
  int unsigned m_busy_cnt, m_stall_cnt;

  // samples of the last applied cycle
  logic        s_start, s_stall, s_ret, s_ehold, s_pend, s_err;
  logic [3:0]  s_rd;
  logic [31:0] s_pb, s_ps;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s at cycle %0d: got %0d expected %0d", nm, cyc, act, exp);
    end
  endtask

  function automatic stim_t idle_s();
    stim_t s;
    s.v = 0; s.op = 0; s.rd = '0; s.rw = 0; s.ra1 = '0; s.ra2 = '0;
    s.dmc = 0; s.rst = 1; s.d = 0; s.L = 1;
    return s;
  endfunction

  task automatic tick(input stim_t s);
    bit pend, busy, ret, launch, stall;
    int done_start;
    @(negedge CLK);
    pend = m_act;
    busy = pend && (cyc >= m_t0 + 1 + m_d) && (cyc <= m_t0 + m_d + m_L);
    bus.ex_mc_valid = s.v;
    bus.ex_mc_op    = s.op;
    bus.ex_rd       = s.rd;
    bus.ex_regwrite = s.rw;
    bus.d_ra1       = s.ra1;
    bus.d_ra2       = s.ra2;
    bus.d_mc_valid  = s.dmc;
    bus.mc_busy     = busy;
    Reset           = s.rst;
    #1;
    done_start = m_t0 + m_d + m_L + 2;
    ret    = pend && (cyc >= done_start) && (!s.rw || (cyc - done_start == int'(MAX_DEFER)));
    launch = !pend && s.v;
    stall  = pend ? ((s.ra1 == m_rd) || (s.ra2 == m_rd) || s.dmc)
                  : (s.v && ((s.ra1 == s.rd) || (s.ra2 == s.rd) || s.dmc));
    s_start = bus.mc_start; s_stall = bus.stall_fd; s_ret = bus.ret_sel;
    s_ehold = bus.e_hold;   s_pend = bus.pending;   s_err = bus.err_overlap;
    s_rd = bus.ret_rd; s_pb = bus.perf_busy_cnt; s_ps = bus.perf_stall_cnt;
    chk("mc_start", {31'b0, s_start}, {31'b0, launch});
    if (launch) chk("mc_op", {31'b0, bus.mc_op}, {31'b0, s.op});
    chk("stall_fd", {31'b0, s_stall}, {31'b0, stall});
    chk("ret_sel", {31'b0, s_ret}, {31'b0, ret});
    chk("e_hold", {31'b0, s_ehold}, {31'b0, ret && s.rw});
    if (ret) chk("ret_rd", {28'b0, s_rd}, {28'b0, m_rd});
    chk("pending", {31'b0, s_pend}, {31'b0, pend});
    chk("err_overlap", {31'b0, s_err}, {31'b0, m_err});
`ifdef MCYCLE_SCHED_PERF_EN
    chk("perf_busy", s_pb, m_busy_cnt);
    chk("perf_stall", s_ps, m_stall_cnt);
`else
    chk("perf_busy", s_pb, 32'd0);
    chk("perf_stall", s_ps, 32'd0);
`endif
    @(posedge CLK);
    if (!s.rst) begin
      m_act = 0; m_err = 0; m_busy_cnt = 0; m_stall_cnt = 0;
    end else begin
      if (pend && s.v) m_err = 1;
      m_busy_cnt  += pend ? 1 : 0;
      m_stall_cnt += stall ? 1 : 0;
      if (ret) m_act = 0;
      if (launch) begin
        m_act = 1; m_t0 = cyc; m_rd = s.rd; m_op = s.op; m_d = s.d; m_L = s.L;
      end
    end
    cyc++;
  endtask

  task automatic do_reset();
    stim_t s;
    s = idle_s();
    s.rst = 0;
    tick(s);
  endtask

  vec_t tbl[7];

  initial begin
    stim_t s;
    int stall_seen;

    // initial reset outside the model-checked path (state unknown before it)
    bus.ex_mc_valid = 0; bus.ex_mc_op = 0; bus.ex_rd = '0; bus.ex_regwrite = 0;
    bus.d_ra1 = '0; bus.d_ra2 = '0; bus.d_mc_valid = 0; bus.mc_busy = 0;
    Reset = 0;
    repeat (2) @(posedge CLK);
    m_act = 0; m_err = 0; m_busy_cnt = 0; m_stall_cnt = 0;
    m_t0 = 0; m_d = 0; m_L = 1; m_rd = '0; m_op = 0;

    // IDLE-state combinational vectors: v op rd ra1 ra2 dmc start stall
    tbl[0] = '{1'b0, 1'b0, 4'd0,  4'd0,  4'd0,  1'b0, 1'b0, 1'b0};
    tbl[1] = '{1'b1, 1'b0, 4'd7,  4'd7,  4'd0,  1'b0, 1'b1, 1'b1};
    tbl[2] = '{1'b1, 1'b1, 4'd7,  4'd2,  4'd3,  1'b1, 1'b1, 1'b1};
    tbl[3] = '{1'b1, 1'b1, 4'd9,  4'd2,  4'd3,  1'b0, 1'b1, 1'b0};
    tbl[4] = '{1'b0, 1'b0, 4'd0,  4'd0,  4'd0,  1'b1, 1'b0, 1'b0};
    tbl[5] = '{1'b1, 1'b0, 4'd15, 4'd1,  4'd15, 1'b0, 1'b1, 1'b1};
    tbl[6] = '{1'b1, 1'b1, 4'd4,  4'd12, 4'd5,  1'b0, 1'b1, 1'b0};
    for (int i = 0; i < 7; i++) begin
      s = idle_s();
      s.v = tbl[i].v; s.op = tbl[i].op; s.rd = tbl[i].rd;
      s.ra1 = tbl[i].ra1; s.ra2 = tbl[i].ra2; s.dmc = tbl[i].dmc;
      tick(s);
      chk($sformatf("tbl%0d_start", i), {31'b0, s_start}, {31'b0, tbl[i].e_start});
      chk($sformatf("tbl%0d_stall", i), {31'b0, s_stall}, {31'b0, tbl[i].e_stall});
      do_reset();
    end

    // launch/retire with free slot, RAW stall on d_ra2=5
    s = idle_s(); s.v = 1; s.rd = 5; s.ra2 = 5; s.L = 8;
    tick(s);
    chk("A_start0", {31'b0, s_start}, 32'd1);
    chk("A_stall0", {31'b0, s_stall}, 32'd1);
    for (int k = 1; k <= 11; k++) begin
      s = idle_s(); s.ra2 = 5;
      tick(s);
      chk("A_nostart", {31'b0, s_start}, 32'd0);
      chk("A_stall", {31'b0, s_stall}, (k <= 10) ? 32'd1 : 32'd0);
      chk("A_ret", {31'b0, s_ret}, (k == 10) ? 32'd1 : 32'd0);
      if (k == 10) chk("A_ret_rd", {28'b0, s_rd}, 32'd5);
      chk("A_pend", {31'b0, s_pend}, (k <= 10) ? 32'd1 : 32'd0);
    end

    // non-dependent D-stage instruction never stalls
    for (int k = 0; k < 8; k++) begin
      s = idle_s(); s.v = (k == 0); s.rd = 5; s.ra1 = 3; s.ra2 = 3; s.d = 1; s.L = 3;
      tick(s);
      chk("B_nostall", {31'b0, s_stall}, 32'd0);
    end

    // forced retire after MAX_DEFER cycles of busy E2M slot
    s = idle_s(); s.v = 1; s.rd = 6; s.L = 2;
    tick(s);
    for (int k = 1; k <= 9; k++) begin
      s = idle_s(); s.rw = 1;
      tick(s);
      chk("C_ret", {31'b0, s_ret}, (k == 8) ? 32'd1 : 32'd0);
      chk("C_ehold", {31'b0, s_ehold}, (k == 8) ? 32'd1 : 32'd0);
      chk("C_pend", {31'b0, s_pend}, (k <= 8) ? 32'd1 : 32'd0);
    end

    // illegal overlap, then reset in RUN
    s = idle_s(); s.v = 1; s.rd = 1; s.L = 5;
    tick(s);
    tick(idle_s());
    s = idle_s(); s.v = 1; s.op = 1; s.rd = 2;
    tick(s);
    chk("D_overlap_nostart", {31'b0, s_start}, 32'd0);
    tick(idle_s());
    chk("D_err", {31'b0, s_err}, 32'd1);
    do_reset();
    tick(idle_s());
    chk("D_rst_pend", {31'b0, s_pend}, 32'd0);
    chk("D_rst_err", {31'b0, s_err}, 32'd0);
    chk("D_rst_outs", {27'b0, s_start, s_stall, s_ret, s_ehold, s_rd != 4'd0}, 32'd0);

    // perf: 8-cycle busy op + 2-cycle deferral
    do_reset();
    stall_seen = 0;
    s = idle_s(); s.v = 1; s.rd = 3; s.ra1 = 3; s.L = 8;
    tick(s);
    stall_seen += s_stall ? 1 : 0;
    for (int k = 1; k <= 12; k++) begin
      s = idle_s(); s.ra1 = (k % 2 == 0) ? 4'd3 : 4'd0; s.rw = (k == 10 || k == 11);
      tick(s);
      stall_seen += s_stall ? 1 : 0;
      if (k == 12) chk("E_ret", {31'b0, s_ret}, 32'd1);
    end
    tick(idle_s());
`ifdef MCYCLE_SCHED_PERF_EN
    chk("E_perf_busy12", s_pb, 32'd12);
    chk("E_perf_stall", s_ps, stall_seen);
`else
    chk("E_perf_busy_off", s_pb, 32'd0);
    chk("E_perf_stall_off", s_ps, 32'd0);
`endif

    // randomized traffic against the timing model
    for (int n = 0; n < 3000; n++) begin
      s = idle_s();
      s.v   = ($urandom % 4) == 0;
      s.op  = 1'($urandom);
      s.rd  = ($urandom % 2) ? 4'($urandom % 4) : 4'($urandom);
      s.rw  = ($urandom % 3) != 0;
      s.ra1 = ($urandom % 2) ? 4'($urandom % 4) : 4'($urandom);
      s.ra2 = ($urandom % 2) ? 4'($urandom % 4) : 4'($urandom);
      s.dmc = ($urandom % 8) == 0;
      s.rst = ($urandom % 200) != 0;
      s.d   = int'($urandom_range(0, 2));
      s.L   = int'($urandom_range(1, 6));
      tick(s);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
